// File: rtl/crc16_pkg.sv
// crc16_pkg: shared FSM states, polynomial select codes and bit/CRC helpers for the CRC16 stream controller
package crc16_pkg;
  typedef enum logic [1:0] {IDLE, RUN, RESULT} state_t;
  localparam logic CRC16_POLY_1021 = 1'b0;
  localparam logic CRC16_POLY_8005 = 1'b1;
  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction
  function automatic logic [15:0] bitrev16(input logic [15:0] b);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = b[15-i];
    return r;
  endfunction
  // MSB-first byte update; reflection is handled outside the engines
  function automatic logic [15:0] crc16_byte(input logic [7:0] d, input logic [15:0] c, input logic [15:0] p);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ p) : (r << 1);
    return r;
  endfunction
endpackage

// File: rtl/crc16_1021.sv
// crc16_1021: combinational byte-wide CRC16 engine, polynomial 0x1021
// ports: data_i byte in, crc_i current CRC, crc_o updated CRC
module crc16_1021
  import crc16_pkg::*;
(
  input  logic [7:0]  data_i,
  input  logic [15:0] crc_i,
  output logic [15:0] crc_o
);
  assign crc_o = crc16_byte(data_i, crc_i, 16'h1021);
endmodule

// File: rtl/crc16_8005.sv
// crc16_8005: combinational byte-wide CRC16 engine, polynomial 0x8005
// ports: data_i byte in, crc_i current CRC, crc_o updated CRC
module crc16_8005
  import crc16_pkg::*;
(
  input  logic [7:0]  data_i,
  input  logic [15:0] crc_i,
  output logic [15:0] crc_o
);
  assign crc_o = crc16_byte(data_i, crc_i, 16'h8005);
endmodule

// File: rtl/crc16_stream_ctrl.sv
// crc16_stream_ctrl: sequences the CRC16 engines over a framed byte stream with valid/ready in and out
// ports: start_i/abort_i job control; poly_sel_i, init_i, refin_i, refout_i, xorout_i, len_i job config
// (sampled on start); data_valid_i/data_i/data_ready_o byte stream; res_valid_o/res_o/res_ready_i result;
// busy_o high outside IDLE
module crc16_stream_ctrl
  import crc16_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             poly_sel_i,
  input  logic [15:0]      init_i,
  input  logic             refin_i,
  input  logic             refout_i,
  input  logic [15:0]      xorout_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             data_valid_i,
  input  logic [7:0]       data_i,
  output logic             data_ready_o,
  output logic             busy_o,
  output logic             res_valid_o,
  output logic [15:0]      res_o,
  input  logic             res_ready_i
);
  state_t state_q;
  logic poly_q, refin_q, refout_q;
  logic [15:0] xorout_q, crc_q, res_q, c1021, c8005, crc_nxt, crc_fin;
  logic [LEN_W-1:0] cnt_q;
  logic [7:0] d;
  assign d = refin_q ? bitrev8(data_i) : data_i;
  crc16_1021 u_1021 (.data_i(d), .crc_i(crc_q), .crc_o(c1021));
  crc16_8005 u_8005 (.data_i(d), .crc_i(crc_q), .crc_o(c8005));
  assign crc_nxt = (poly_q == CRC16_POLY_8005) ? c8005 : c1021;
  assign crc_fin = (refout_q ? bitrev16(crc_nxt) : crc_nxt) ^ xorout_q;
  // outputs decode the state flop directly, so they carry no combinational input paths
  assign data_ready_o = state_q == RUN;
  assign busy_o = state_q != IDLE;
  assign res_valid_o = state_q == RESULT;
  assign res_o = res_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      poly_q <= 1'b0;
      refin_q <= 1'b0;
      refout_q <= 1'b0;
      xorout_q <= '0;
      crc_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else if (abort_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          poly_q <= poly_sel_i;
          refin_q <= refin_i;
          refout_q <= refout_i;
          xorout_q <= xorout_i;
          crc_q <= init_i;
          cnt_q <= len_i;
          res_q <= (refout_i ? bitrev16(init_i) : init_i) ^ xorout_i;
          state_q <= (len_i == '0) ? RESULT : RUN;
        end
        RUN: if (data_valid_i) begin
          crc_q <= crc_nxt;
          cnt_q <= cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            res_q <= crc_fin;
            state_q <= RESULT;
          end
        end
        RESULT: if (res_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc16_stream_ctrl.sv
// tb_crc16_stream_ctrl: table-driven directed check of crc16_stream_ctrl against catalogue CRC16 values
module tb_crc16_stream_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, poly = 1'b0, refin = 1'b0, refout = 1'b0;
  logic [15:0] init = '0, xorout = '0, res;
  logic [15:0] len = '0;
  logic data_valid = 1'b0, res_ready = 1'b0, data_ready, busy, res_valid;
  logic [7:0] data = '0;
  logic [7:0] msg [9];
  int n_vec = 0, n_bad = 0;
  typedef struct {
    logic poly;
    logic [15:0] init;
    logic refin;
    logic refout;
    logic [15:0] xorout;
    int len;
    bit gaps;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [7];
  crc16_stream_ctrl #(.LEN_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort), .poly_sel_i(poly),
    .init_i(init), .refin_i(refin), .refout_i(refout), .xorout_i(xorout), .len_i(len),
    .data_valid_i(data_valid), .data_i(data), .data_ready_o(data_ready), .busy_o(busy),
    .res_valid_o(res_valid), .res_o(res), .res_ready_i(res_ready)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: act=%b req=%b t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: act=%h req=%h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic scramble_cfg();
    poly = ~poly;
    init = 16'($urandom);
    refin = ~refin;
    refout = ~refout;
    xorout = 16'($urandom);
    len = 16'h0000;
  endtask
  task automatic start_job(input vec_t v);
    @(negedge clk);
    chk1("idle_ready", data_ready, 1'b0);
    poly = v.poly;
    init = v.init;
    refin = v.refin;
    refout = v.refout;
    xorout = v.xorout;
    len = 16'(v.len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_cfg();
    chk1("busy_after_start", busy, 1'b1);
    chk1("ready_after_start", data_ready, v.len != 0);
    chk1("valid_after_start", res_valid, v.len == 0);
  endtask
  task automatic feed(input int n, input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 200) begin
      if (guard > 0) @(negedge clk);
      guard++;
      chk1("ready_run", data_ready, 1'b1);
      chk1("no_early_valid", res_valid, 1'b0);
      if (gaps && $urandom_range(0, 2) == 0) data_valid = 1'b0;
      else begin
        data_valid = 1'b1;
        data = msg[i];
        i++;
      end
    end
    @(negedge clk);
    data_valid = 1'b0;
    chk1("feed_done", i == n, 1'b1);
  endtask
  task automatic finish_job(input logic [15:0] exp, input int hold, input bit pulse);
    chk1("res_valid", res_valid, 1'b1);
    chk16("res", res, exp);
    chk1("result_ready", data_ready, 1'b0);
    for (int k = 0; k < hold; k++) begin
      start = pulse;
      @(negedge clk);
      chk1("hold_valid", res_valid, 1'b1);
      chk16("hold_res", res, exp);
    end
    res_ready = 1'b1;
    start = pulse;
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    chk1("valid_drop", res_valid, 1'b0);
    chk1("idle_busy", busy, 1'b0);
  endtask
  task automatic run_vec(input vec_t v);
    start_job(v);
    if (v.len != 0) feed(v.len, v.gaps);
    finish_job(v.exp, 0, 1'b0);
  endtask
  initial begin
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    vecs[0] = '{1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 9, 1'b0, 16'h29B1};
    vecs[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 9, 1'b1, 16'h31C3};
    vecs[2] = '{1'b1, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 9, 1'b0, 16'h4B37};
    vecs[3] = '{1'b1, 16'h0000, 1'b1, 1'b1, 16'h0000, 9, 1'b1, 16'hBB3D};
    vecs[4] = '{1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 9, 1'b0, 16'hFEE8};
    vecs[5] = '{1'b0, 16'h1234, 1'b0, 1'b0, 16'hFFFF, 0, 1'b0, 16'hEDCB};
    vecs[6] = '{1'b0, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 9, 1'b1, 16'hD64E};
    #1;
    chk1("rst_ready", data_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_valid", res_valid, 1'b0);
    chk16("rst_res", res, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 7; j++) run_vec(vecs[j]);
    // result held under back-pressure; start pulses in RESULT and in the handshake cycle are ignored
    start_job(vecs[0]);
    feed(9, 1'b0);
    finish_job(16'h29B1, 5, 1'b1);
    repeat (2) @(negedge clk);
    chk1("ignored_start_idle", busy, 1'b0);
    run_vec(vecs[4]);
    // abort after 4 bytes while a fifth byte is handshaking
    start_job(vecs[0]);
    feed(4, 1'b0);
    data_valid = 1'b1;
    data = msg[4];
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    data_valid = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_ready", data_ready, 1'b0);
    chk1("abort_valid", res_valid, 1'b0);
    repeat (3) @(negedge clk);
    chk1("abort_no_result", res_valid, 1'b0);
    run_vec(vecs[0]);
    // abort together with start in IDLE stays IDLE
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    len = 16'd0;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk1("abort_start_busy", busy, 1'b0);
    chk1("abort_start_valid", res_valid, 1'b0);
    // asynchronous reset in the middle of a job
    start_job(vecs[2]);
    feed(3, 1'b0);
    chk1("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_ready", data_ready, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_valid", res_valid, 1'b0);
    chk16("mid_rst_res", res, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[1]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
